// File: rtl/div_pkg.sv
// Shared FSM state, width defaults and the special-case result function
// used by both the fast path and the iterative path of the divider.
package div_pkg;
   localparam int DIV_XLEN_DEF  = 64;
   localparam int DIV_TAG_W_DEF = 5;
   localparam int DIV_WORD_W    = 32;
   localparam int DIV_MAX_W     = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_e;

   typedef struct packed {
      logic [DIV_MAX_W-1:0] quo;
      logic [DIV_MAX_W-1:0] rem;
   } div_res_t;

   // Results are W bits wide here; the caller sign-extends word results.
   function automatic div_res_t div_special_result(input logic [DIV_MAX_W-1:0] dividend,
                                                   input logic                 is_word,
                                                   input logic                 div_zero);
      div_res_t res;
      if (div_zero) begin
         res.quo = is_word ? 64'h0000_0000_FFFF_FFFF : '1;
         res.rem = dividend;
      end else begin
         res.quo = dividend;
         res.rem = '0;
      end
      return res;
   endfunction
endpackage

// File: rtl/div_operand_prep.sv
// Combinational operand preparation: word truncation/extension, magnitudes,
// result signs and detection of divide-by-zero and signed overflow.
module div_operand_prep import div_pkg::*; #(
   parameter int XLEN = DIV_XLEN_DEF
) (
   input  logic [XLEN-1:0] dividend_i,
   input  logic [XLEN-1:0] divisor_i,
   input  logic            is_signed_i,
   input  logic            is_word_i,
   output logic            word_o,
   output logic [XLEN-1:0] mag_x_o,
   output logic [XLEN-1:0] mag_y_o,
   output logic            quo_neg_o,
   output logic            rem_neg_o,
   output logic            special_o,
   output logic [XLEN-1:0] spec_quo_o,
   output logic [XLEN-1:0] spec_rem_o
);
   localparam logic [XLEN-1:0] WORD_MIN = ~((XLEN'(1) << (DIV_WORD_W - 1)) - XLEN'(1));
   localparam logic [XLEN-1:0] FULL_MIN = XLEN'(1) << (XLEN - 1);

   function automatic logic [XLEN-1:0] ext_word(input logic [XLEN-1:0] v, input logic sgn);
      logic [XLEN-1:0] r;
      r = v;
      for (int i = DIV_WORD_W; i < XLEN; i++) r[i] = sgn & v[DIV_WORD_W-1];
      return r;
   endfunction

   logic [XLEN-1:0] x_t, y_t, min_val;
   logic            x_neg, y_neg, div_zero, ovf;
   div_res_t        spec;

   assign word_o    = is_word_i && (XLEN > DIV_WORD_W);
   assign x_t       = word_o ? ext_word(dividend_i, is_signed_i) : dividend_i;
   assign y_t       = word_o ? ext_word(divisor_i, is_signed_i) : divisor_i;

   // After extension bit XLEN-1 carries the sign of bit W-1 in both modes.
   assign x_neg     = is_signed_i & x_t[XLEN-1];
   assign y_neg     = is_signed_i & y_t[XLEN-1];
   assign mag_x_o   = x_neg ? -x_t : x_t;
   assign mag_y_o   = y_neg ? -y_t : y_t;
   assign quo_neg_o = x_neg ^ y_neg;
   assign rem_neg_o = x_neg;

   assign min_val   = word_o ? WORD_MIN : FULL_MIN;
   assign div_zero  = (y_t == '0);
   assign ovf       = is_signed_i && (x_t == min_val) && (y_t == '1);
   assign special_o = div_zero | ovf;

   assign spec       = div_special_result(DIV_MAX_W'(x_t), word_o, div_zero);
   assign spec_quo_o = spec.quo[XLEN-1:0];
   assign spec_rem_o = spec.rem[XLEN-1:0];
endmodule

// File: rtl/iter_divider.sv
// Radix-2 restoring divider, W+1 cycles accept-to-valid (1 for specials with DIV_FAST_SPECIAL_EN);
// result held in DONE until out_ready, no new accept until back in IDLE.
module iter_divider import div_pkg::*; #(
   parameter int XLEN  = DIV_XLEN_DEF,
   parameter int TAG_W = DIV_TAG_W_DEF
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  in_dividend,
   input  logic [XLEN-1:0]  in_divisor,
   input  logic             in_signed,
   input  logic             in_word,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_quotient,
   output logic [XLEN-1:0]  out_remainder,
   output logic [TAG_W-1:0] out_tag
);
   localparam int CNT_W      = $clog2(XLEN);
   localparam int WORD_SHIFT = XLEN - DIV_WORD_W;

   function automatic logic [XLEN-1:0] word_sext(input logic [XLEN-1:0] v, input logic en);
      logic [XLEN-1:0] r;
      r = v;
      if (en) for (int i = DIV_WORD_W; i < XLEN; i++) r[i] = v[DIV_WORD_W-1];
      return r;
   endfunction

   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [XLEN-1:0]  rem_q, dvd_q, dvs_q;
   logic [XLEN-1:0]  spec_quo_q, spec_rem_q;
   logic             quo_neg_q, rem_neg_q, word_q, special_q;
   logic [TAG_W-1:0] tag_q;
   logic [XLEN-1:0]  out_quo_q, out_rem_q;
   logic [TAG_W-1:0] out_tag_q;

   logic             p_word, p_quo_neg, p_rem_neg, p_special;
   logic [XLEN-1:0]  p_mag_x, p_mag_y, p_spec_quo, p_spec_rem;

   logic             accept, fast_special, qbit;
   logic [XLEN:0]    rem_sh, diff;
   logic [XLEN-1:0]  rem_nx, dvd_nx, quo_fin, rem_fin;

   div_operand_prep #(.XLEN(XLEN)) u_prep (
      .dividend_i  (in_dividend),
      .divisor_i   (in_divisor),
      .is_signed_i (in_signed),
      .is_word_i   (in_word),
      .word_o      (p_word),
      .mag_x_o     (p_mag_x),
      .mag_y_o     (p_mag_y),
      .quo_neg_o   (p_quo_neg),
      .rem_neg_o   (p_rem_neg),
      .special_o   (p_special),
      .spec_quo_o  (p_spec_quo),
      .spec_rem_o  (p_spec_rem)
   );

`ifdef DIV_FAST_SPECIAL_EN
   assign fast_special = p_special;
`else
   assign fast_special = 1'b0;
`endif

   assign accept = in_valid && in_ready;

   // One restoring step: the quotient bit shifts into the dividend register.
   assign rem_sh  = {rem_q, dvd_q[XLEN-1]};
   assign diff    = rem_sh - {1'b0, dvs_q};
   assign qbit    = ~diff[XLEN];
   assign rem_nx  = qbit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
   assign dvd_nx  = {dvd_q[XLEN-2:0], qbit};
   assign quo_fin = special_q ? spec_quo_q : (quo_neg_q ? -dvd_nx : dvd_nx);
   assign rem_fin = special_q ? spec_rem_q : (rem_neg_q ? -rem_nx : rem_nx);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (accept) state_d = fast_special ? DONE : CALC;
            CALC:    if (cnt_q == '0) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      in_ready  = (state_q == IDLE) && !flush && resetn;
      out_valid = (state_q == DONE);
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         cnt_q      <= '0;
         rem_q      <= '0;
         dvd_q      <= '0;
         dvs_q      <= '0;
         spec_quo_q <= '0;
         spec_rem_q <= '0;
         quo_neg_q  <= 1'b0;
         rem_neg_q  <= 1'b0;
         word_q     <= 1'b0;
         special_q  <= 1'b0;
         tag_q      <= '0;
         out_quo_q  <= '0;
         out_rem_q  <= '0;
         out_tag_q  <= '0;
      end else if (accept) begin
         // Word dividends are left-aligned so the MSB enters the remainder first.
         cnt_q      <= p_word ? CNT_W'(DIV_WORD_W - 1) : CNT_W'(XLEN - 1);
         rem_q      <= '0;
         dvd_q      <= p_word ? (p_mag_x << WORD_SHIFT) : p_mag_x;
         dvs_q      <= p_mag_y;
         spec_quo_q <= p_spec_quo;
         spec_rem_q <= p_spec_rem;
         quo_neg_q  <= p_quo_neg;
         rem_neg_q  <= p_rem_neg;
         word_q     <= p_word;
         special_q  <= p_special;
         tag_q      <= in_tag;
         if (fast_special) begin
            out_quo_q <= word_sext(p_spec_quo, p_word);
            out_rem_q <= word_sext(p_spec_rem, p_word);
            out_tag_q <= in_tag;
         end
      end else if (state_q == CALC && !flush) begin
         cnt_q <= cnt_q - CNT_W'(1);
         rem_q <= rem_nx;
         dvd_q <= dvd_nx;
         if (cnt_q == '0) begin
            out_quo_q <= word_sext(quo_fin, word_q);
            out_rem_q <= word_sext(rem_fin, word_q);
            out_tag_q <= tag_q;
         end
      end
   end

   assign out_quotient  = out_quo_q;
   assign out_remainder = out_rem_q;
   assign out_tag       = out_tag_q;
endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider (XLEN=64) with an arithmetic reference model
// and a per-cycle output comparator.
module tb_iter_divider;
   localparam int XLEN  = 64;
   localparam int TAG_W = 5;
`ifdef DIV_FAST_SPECIAL_EN
   localparam bit FAST_EN = 1'b1;
`else
   localparam bit FAST_EN = 1'b0;
`endif

   logic             clock;
   logic             resetn;
   logic             in_valid, in_ready, in_signed, in_word, flush;
   logic [XLEN-1:0]  in_dividend, in_divisor;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid, out_ready;
   logic [XLEN-1:0]  out_quotient, out_remainder;
   logic [TAG_W-1:0] out_tag;

   iter_divider #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
      .clock         (clock),
      .resetn        (resetn),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_dividend   (in_dividend),
      .in_divisor    (in_divisor),
      .in_signed     (in_signed),
      .in_word       (in_word),
      .in_tag        (in_tag),
      .flush         (flush),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_quotient  (out_quotient),
      .out_remainder (out_remainder),
      .out_tag       (out_tag)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_pass  = 0;
   int n_total = 0;

   logic [63:0]      exp_q, exp_r;
   logic [TAG_W-1:0] exp_tag;
   int               exp_lat, lat_base;
   bit               pending = 0, seen = 0, hs_prev = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // RISC-V division semantics computed with native arithmetic.
   function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                 input logic s, input logic w,
                                 output logic [63:0] q, output logic [63:0] r);
      logic [31:0] a32, b32, q32, r32;
      int          sa, sb;
      longint      la, lb;
      if (w) begin
         a32 = a[31:0];
         b32 = b[31:0];
         if (b32 == 32'd0) begin
            q32 = '1; r32 = a32;
         end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
            q32 = a32; r32 = 32'd0;
         end else if (s) begin
            sa = a32; sb = b32;
            q32 = sa / sb; r32 = sa % sb;
         end else begin
            q32 = a32 / b32; r32 = a32 % b32;
         end
         q = {{32{q32[31]}}, q32};
         r = {{32{r32[31]}}, r32};
      end else begin
         if (b == 64'd0) begin
            q = '1; r = a;
         end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
            q = a; r = 64'd0;
         end else if (s) begin
            la = a; lb = b;
            q = la / lb; r = la % lb;
         end else begin
            q = a / b; r = a % b;
         end
      end
   endfunction

   task automatic send(input string name, input logic [63:0] a, input logic [63:0] b,
                       input logic s, input logic w, input logic [TAG_W-1:0] tag,
                       input logic [63:0] hq, input logic [63:0] hr);
      logic [63:0] mq, mr;
      bit          ok, sp;
      int          wd;
      model(a, b, s, w, mq, mr);
      chk({name, "_model_q"}, mq, hq);
      chk({name, "_model_r"}, mr, hr);
      wd = w ? 32 : 64;
      sp = w ? (b[31:0] == 32'd0 || (s && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF))
             : (b == 64'd0 || (s && a == 64'h8000_0000_0000_0000 && b == '1));
      @(posedge clock); #1;
      in_dividend = a; in_divisor = b; in_signed = s; in_word = w; in_tag = tag;
      in_valid = 1'b1;
      ok = 0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clock);
         if (in_ready) ok = 1;
      end
      if (!ok) begin
         n_total++;
         $display("FAIL %s_accept: in_ready stayed 0, required 1 within 200 cycles", name);
         in_valid = 1'b0;
         return;
      end
      lat_base = cyc;
      @(posedge clock); #1;
      in_valid = 1'b0;
      exp_q   = mq;
      exp_r   = mr;
      exp_tag = tag;
      exp_lat = (sp && FAST_EN) ? 1 : wd + 1;
      seen    = 0;
      pending = 1;
   endtask

   task automatic wait_done(input string name);
      int i;
      i = 0;
      while (pending && i < 300) begin
         @(negedge clock);
         i++;
      end
      if (pending) begin
         n_total++;
         $display("FAIL %s_done: no result handshake, required one within 300 cycles", name);
         pending = 0;
      end
      @(negedge clock);
   endtask

   // Compare DUT outputs to the model on every cycle a result is presented.
   always @(negedge clock) begin
      if (hs_prev) begin
         hs_prev = 0;
         chk("post_hs_out_valid", 64'(out_valid), 64'(0));
         chk("post_hs_in_ready", 64'(in_ready), 64'(1));
      end
      if (out_valid) begin
         if (!pending) begin
            n_total++;
            $display("FAIL unexpected_out_valid: out_valid=1, required 0 (no request outstanding)");
         end else begin
            if (!seen) begin
               seen = 1;
               chk("latency", 64'(cyc - lat_base), 64'(exp_lat));
            end
            chk("quotient", out_quotient, exp_q);
            chk("remainder", out_remainder, exp_r);
            chk("tag", 64'(out_tag), 64'(exp_tag));
            chk("in_ready_busy", 64'(in_ready), 64'(0));
            if (out_ready) begin
               pending = 0;
               hs_prev = 1;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      resetn = 1'b0; in_valid = 1'b0; in_dividend = '0; in_divisor = '0;
      in_signed = 1'b0; in_word = 1'b0; in_tag = '0; flush = 1'b0; out_ready = 1'b1;
      #3;
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_quotient", out_quotient, 64'd0);
      chk("rst_remainder", out_remainder, 64'd0);
      chk("rst_tag", 64'(out_tag), 64'(0));
      chk("rst_in_ready", 64'(in_ready), 64'(0));
      repeat (3) @(posedge clock);
      #2 resetn = 1'b1;
      @(negedge clock);
      chk("idle_in_ready", 64'(in_ready), 64'(1));

      send("u64_100_7", 64'd100, 64'd7, 1'b0, 1'b0, 5'h01, 64'd14, 64'd2);
      wait_done("u64_100_7");
      send("sw_m7_2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b1, 5'h02,
           64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF);
      wait_done("sw_m7_2");
      send("s64_div0", 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 1'b1, 1'b0, 5'h1A,
           64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB);
      wait_done("s64_div0");
      send("s64_ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 5'h04,
           64'h8000_0000_0000_0000, 64'd0);
      wait_done("s64_ovf");
      send("sw_ovf", 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, 5'h05,
           64'hFFFF_FFFF_8000_0000, 64'd0);
      wait_done("sw_ovf");
      send("uw_div0", 64'h1234_5678_9ABC_DEF0, 64'h0000_0001_0000_0000, 1'b0, 1'b1, 5'h06,
           64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_9ABC_DEF0);
      wait_done("uw_div0");
      send("s64_m100_7", 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b1, 1'b0, 5'h07,
           64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE);
      wait_done("s64_m100_7");
      send("s64_100_m7", 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1, 1'b0, 5'h08,
           64'hFFFF_FFFF_FFFF_FFF2, 64'd2);
      wait_done("s64_100_m7");
      send("u64_max_16", 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 1'b0, 1'b0, 5'h09,
           64'h0FFF_FFFF_FFFF_FFFF, 64'hF);
      wait_done("u64_max_16");
      send("uw_sext", 64'h1234_5678_FFFF_FFFE, 64'd1, 1'b0, 1'b1, 5'h0A,
           64'hFFFF_FFFF_FFFF_FFFE, 64'd0);
      wait_done("uw_sext");

      // Backpressure: hold the result for three cycles.
      out_ready = 1'b0;
      send("bp", 64'd1000, 64'd10, 1'b0, 1'b0, 5'h0B, 64'd100, 64'd0);
      for (int i = 0; i < 200 && !out_valid; i++) @(negedge clock);
      repeat (3) @(posedge clock);
      #1 out_ready = 1'b1;
      wait_done("bp");
      send("bp_next", 64'd77, 64'd5, 1'b0, 1'b0, 5'h0C, 64'd15, 64'd2);
      wait_done("bp_next");

      // Flush in the tenth CALC cycle.
      send("flush", 64'd12345, 64'd17, 1'b0, 1'b0, 5'h0D, 64'd726, 64'd3);
      repeat (9) @(posedge clock);
      #1 flush = 1'b1;
      pending = 0;
      @(posedge clock);
      #1 flush = 1'b0;
      @(negedge clock);
      chk("flush_in_ready", 64'(in_ready), 64'(1));
      chk("flush_out_valid", 64'(out_valid), 64'(0));
      @(posedge clock);
      #1 in_valid = 1'b1; flush = 1'b1;
      @(negedge clock);
      chk("flush_blocks_in_ready", 64'(in_ready), 64'(0));
      @(posedge clock);
      #1 in_valid = 1'b0; flush = 1'b0;
      @(negedge clock);
      chk("flush_no_accept", 64'(in_ready), 64'(1));
      repeat (70) @(negedge clock);

      // Asynchronous reset in the middle of CALC.
      send("rst_mid", 64'd999, 64'd3, 1'b0, 1'b0, 5'h0E, 64'd333, 64'd0);
      repeat (20) @(posedge clock);
      #2 resetn = 1'b0;
      pending = 0;
      #1;
      chk("midrst_out_valid", 64'(out_valid), 64'(0));
      chk("midrst_quotient", out_quotient, 64'd0);
      chk("midrst_remainder", out_remainder, 64'd0);
      chk("midrst_tag", 64'(out_tag), 64'(0));
      chk("midrst_in_ready", 64'(in_ready), 64'(0));
      repeat (2) @(posedge clock);
      #2 resetn = 1'b1;
      send("post_rst", 64'd50, 64'd8, 1'b0, 1'b0, 5'h0F, 64'd6, 64'd2);
      wait_done("post_rst");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/iter_divider.md
# iter_divider

Parametrised iterative radix-2 integer divider for the execute-stage multi-cycle unit, successor to the fixed 64-bit `Divider`. Supports XLEN-wide and 32-bit word operations, signed and unsigned, with RISC-V divide-by-zero and overflow semantics. Inputs and results use valid/ready handshakes on both sides, and the result port accepts backpressure. An optional tag passes through unchanged for writeback matching, and a flush input kills the operation in flight.

## Interface
- XLEN, 64, datapath width; legal values 32 or 64.
- TAG_W, 5, width of the pass-through tag.
- clock  in  1  rising-edge clock.
- resetn  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  divider idle; accepts a request.
- in_dividend  in  XLEN  dividend.
- in_divisor  in  XLEN  divisor.
- in_signed  in  1  1 = signed operation.
- in_word  in  1  1 = 32-bit word op (DIVW/REMW class); ignored when XLEN=32.
- in_tag  in  TAG_W  tag captured with the request.
- flush  in  1  kill the operation in flight.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_quotient  out  XLEN  quotient.
- out_remainder  out  XLEN  remainder.
- out_tag  out  TAG_W  tag of the result.

## Operation
- FSM states: IDLE, CALC, DONE. Reset state is IDLE.
- in_ready is high only in IDLE with flush low.
- Accept occurs when in_valid and in_ready are both high. On accept:
  - Effective width W = 32 if in_word (and XLEN=64), else XLEN.
  - Operands are truncated to W bits. When signed, operands are sign-extended from bit W-1.
  - Magnitudes and sign flags are captured. Quotient sign = sign(x) XOR sign(y). Remainder sign = sign(x).
- CALC: restoring division, one quotient bit per cycle, W iterations. An iteration counter counts down from W-1.
- The last iteration applies sign correction. In word mode it also sign-extends the 32-bit results to XLEN; this applies to both signed and unsigned word ops.
- Special cases, with the result before word sign-extension:
  - Divisor = 0: quotient = all ones (W bits); remainder = dividend.
  - Signed, dividend = −2^(W−1), divisor = −1: quotient = dividend; remainder = 0.
- DONE: out_valid high. Outputs and out_tag hold stable until out_ready. On the handshake, go to IDLE next cycle. There is no accept in the same cycle as the output handshake.
- flush (synchronous, any state): next state IDLE, out_valid low, in-flight result discarded. A request presented with flush high is not accepted.
- resetn low (asynchronous, any time): state IDLE; all outputs 0 except in_ready, which goes to 1 once resetn deasserts.

## Timing
- Accept at edge T. CALC occupies cycles T+1..T+W. out_valid rises at T+W+1: 65 cycles for 64-bit ops, 33 for word ops.
- With the fast-path macro enabled, special cases have out_valid at T+1.
- out_valid drops the cycle after the out_ready handshake. in_ready rises that same cycle.
- Throughput: one operation per W+2 cycles at best.
- Reset values: out_valid=0, out_quotient=0, out_remainder=0, out_tag=0. in_ready=0 while resetn is low.

## Configuration
- DIV_FAST_SPECIAL_EN defined: divide-by-zero and signed overflow are detected at accept. The FSM goes IDLE→DONE directly, so the result is available at T+1.
- Not defined: special cases run the full W iterations. Results are identical; only latency differs. The special-case result mux is present in both builds.

## Structure
- Shared package div_pkg holds:
  - the FSM state enum `div_state_e`;
  - the XLEN and TAG_W defaults;
  - the word-width constant 32;
  - a function computing special-case results.
- Sub-module div_operand_prep is combinational. It performs word truncation/extension, magnitude computation and special-case detection.
- iter_divider holds the FSM, counter, shift registers and output registers.

## Test plan
All scenarios use XLEN=64.
- Unsigned 64-bit: 100 / 7, out_ready=1 → q=14, r=2; out_valid exactly 65 cycles after accept.
- Signed word: dividend 0xFFFFFFFF_FFFFFFF9, divisor 2 → q=0xFFFFFFFF_FFFFFFFD, r=0xFFFFFFFF_FFFFFFFF; latency 33.
- Divide by zero, signed 64: dividend −5, divisor 0, tag 0x1A → q=0xFFFFFFFF_FFFFFFFF, r=0xFFFFFFFF_FFFFFFFB, out_tag=0x1A.
  - Latency 1 with DIV_FAST_SPECIAL_EN, 65 without.
- Overflow: dividend 0x80000000_00000000, divisor 0xFFFFFFFF_FFFFFFFF, signed → q=0x80000000_00000000, r=0.
  - Word variant: dividend 0x80000000, divisor 0xFFFFFFFF → q=0xFFFFFFFF_80000000, r=0.
- Backpressure: out_ready held low 3 cycles after out_valid → outputs stable and in_ready low throughout.
  - On release: in_ready high the next cycle, and a new accept succeeds.
- Flush and reset:
  - flush at the 10th CALC cycle → no out_valid, in_ready high the next cycle.
  - resetn pulsed low mid-CALC → all outputs 0 immediately; the next request completes correctly.
